// File: rtl/bus_watchdog_pkg.sv
// Shared types and defaults for the per-requester bus watchdog.
// Holds the channel FSM state type, default sizing constants and a
// width helper used for the timeout channel index port.
package bus_watchdog_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    TMO  = 2'd2
  } wd_state_t;

  localparam int WD_NUM_CPUS       = 4;
  localparam int WD_TIMEOUT_CYCLES = 20;
  localparam int WD_CNT_W          = 16;

  // Index width for n items, never narrower than one bit so a single
  // channel still gets a usable port.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bus_wd_channel.sv
// One watchdog channel: request/ack FSM, wait-latency counter, sticky
// timeout and protocol-error flags, and optional statistics.
// Statistics (max latency, completion count) exist only when
// WATCHDOG_STATS_EN is defined; otherwise those outputs are tied to 0.
module bus_wd_channel
  import bus_watchdog_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = WD_TIMEOUT_CYCLES,
  parameter int CNT_W          = WD_CNT_W
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_req,
  input  logic             i_ack,
  input  logic             i_clear,
  output logic             o_timeoutFlag,
  output logic             o_protoErr,
  output logic [CNT_W-1:0] o_maxLat,
  output logic [CNT_W-1:0] o_doneCnt
);

  localparam int LAT_W = $clog2(TIMEOUT_CYCLES + 1);
  // Latency value in the last cycle that can still complete on time.
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(TIMEOUT_CYCLES - 1);

  wd_state_t        r_state;
  wd_state_t        w_stateNext;
  logic [LAT_W-1:0] r_lat;
  logic [LAT_W-1:0] w_latNext;
  logic             w_setTmo;
  logic             w_setProto;
  logic             r_timeoutFlag;
  logic             r_protoErr;

  // State and latency registers; reset abandons any transaction in flight.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_lat   <= '0;
    end else begin
      r_state <= w_stateNext;
      r_lat   <= w_latNext;
    end
  end

  // Next-state logic; latency counts the cycles a request has waited.
  always_comb begin
    w_stateNext = r_state;
    w_latNext   = r_lat;
    w_setTmo    = 1'b0;
    w_setProto  = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_req && !i_ack) begin
          w_stateNext = WAIT;
          w_latNext   = LAT_W'(1);
        end
      end
      WAIT: begin
        if (i_ack) begin
          w_stateNext = IDLE;
          w_latNext   = '0;
        end else if (!i_req) begin
          w_stateNext = IDLE;
          w_latNext   = '0;
          w_setProto  = 1'b1;
        end else begin
          w_latNext = r_lat + LAT_W'(1);
          if (r_lat == LAT_LAST) begin
            w_stateNext = TMO;
            w_setTmo    = 1'b1;
          end
        end
      end
      TMO: begin
        if (i_ack || !i_req) begin
          w_stateNext = IDLE;
          w_latNext   = '0;
        end
      end
      default: begin
        w_stateNext = IDLE;
        w_latNext   = '0;
      end
    endcase
  end

  // Sticky flags: a new event in the same cycle beats a clear request.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_timeoutFlag <= 1'b0;
      r_protoErr    <= 1'b0;
    end else begin
      if (w_setTmo) begin
        r_timeoutFlag <= 1'b1;
      end else if (i_clear) begin
        r_timeoutFlag <= 1'b0;
      end
      if (w_setProto) begin
        r_protoErr <= 1'b1;
      end else if (i_clear) begin
        r_protoErr <= 1'b0;
      end
    end
  end

  assign o_timeoutFlag = r_timeoutFlag;
  assign o_protoErr    = r_protoErr;

`ifdef WATCHDOG_STATS_EN
  localparam int MW = (CNT_W > LAT_W) ? CNT_W : LAT_W;
  localparam logic [MW-1:0] CNT_MAX = MW'({CNT_W{1'b1}});

  logic             w_complete;
  logic [MW-1:0]    w_latExt;
  logic [CNT_W-1:0] w_latSat;
  logic [CNT_W-1:0] r_maxLat;
  logic [CNT_W-1:0] r_doneCnt;

  // r_lat is always 0 in IDLE, so it is the completion latency in both cases.
  assign w_complete = ((r_state == IDLE) && i_req && i_ack) ||
                      ((r_state == WAIT) && i_ack);
  assign w_latExt   = MW'(r_lat);
  assign w_latSat   = (w_latExt > CNT_MAX) ? '1 : w_latExt[CNT_W-1:0];

  // Statistics update on every on-time completion; late acks are ignored.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_maxLat  <= '0;
      r_doneCnt <= '0;
    end else if (w_complete) begin
      if (r_doneCnt != '1) begin
        r_doneCnt <= r_doneCnt + CNT_W'(1);
      end
      if (w_latSat > r_maxLat) begin
        r_maxLat <= w_latSat;
      end
    end
  end

  assign o_maxLat  = r_maxLat;
  assign o_doneCnt = r_doneCnt;
`else
  assign o_maxLat  = '0;
  assign o_doneCnt = '0;
`endif

endmodule

// File: rtl/bus_req_watchdog.sv
// Per-requester bus watchdog: one independent channel monitor per CPU
// plus a lowest-index priority encoder for the timed-out channel.
// Define WATCHDOG_STATS_EN to build the max_lat / done_cnt statistics.
module bus_req_watchdog
  import bus_watchdog_pkg::*;
#(
  parameter int NUM_CPUS       = WD_NUM_CPUS,
  parameter int TIMEOUT_CYCLES = WD_TIMEOUT_CYCLES,
  parameter int CNT_W          = WD_CNT_W
) (
  input  logic                              CLK,
  input  logic                              RST,
  input  logic [NUM_CPUS-1:0]               req,
  input  logic [NUM_CPUS-1:0]               ack,
  input  logic [NUM_CPUS-1:0]               clear,
  output logic [NUM_CPUS-1:0]               timeout_flag,
  output logic [NUM_CPUS-1:0]               proto_err,
  output logic                              timeout_any,
  output logic [clog2_min1(NUM_CPUS)-1:0]   timeout_ch,
  output logic [NUM_CPUS*CNT_W-1:0]         max_lat,
  output logic [NUM_CPUS*CNT_W-1:0]         done_cnt
);

  localparam int CH_W = clog2_min1(NUM_CPUS);

  logic [CH_W-1:0] w_tmoCh;

  for (genvar g = 0; g < NUM_CPUS; g++) begin : g_ch
    bus_wd_channel #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
      .CNT_W         (CNT_W)
    ) u_ch (
      .i_clk        (CLK),
      .i_rst        (RST),
      .i_req        (req[g]),
      .i_ack        (ack[g]),
      .i_clear      (clear[g]),
      .o_timeoutFlag(timeout_flag[g]),
      .o_protoErr   (proto_err[g]),
      .o_maxLat     (max_lat[g*CNT_W +: CNT_W]),
      .o_doneCnt    (done_cnt[g*CNT_W +: CNT_W])
    );
  end

  // Lowest-index timed-out channel wins; scanning downward lets it overwrite.
  always_comb begin
    w_tmoCh = '0;
    for (int i = NUM_CPUS - 1; i >= 0; i--) begin
      if (timeout_flag[i]) begin
        w_tmoCh = CH_W'(i);
      end
    end
  end

  assign timeout_ch  = w_tmoCh;
  assign timeout_any = |timeout_flag;

endmodule

// File: tb/tb_bus_req_watchdog.sv
// Self-checking bench for bus_req_watchdog (4 channels, 20-cycle timeout).
// A cycle-level behavioural model tracks each requester's outstanding
// request age and flags; directed scenarios are followed by random traffic.
module tb_bus_req_watchdog;

  localparam int N = 4;
  localparam int T = 20;
  localparam int W = 16;
  localparam int CNT_SAT = (1 << W) - 1;

  logic           CLK = 1'b0;
  logic           RST;
  logic [N-1:0]   req;
  logic [N-1:0]   ack;
  logic [N-1:0]   clear;
  logic [N-1:0]   timeout_flag;
  logic [N-1:0]   proto_err;
  logic           timeout_any;
  logic [1:0]     timeout_ch;
  logic [N*W-1:0] max_lat;
  logic [N*W-1:0] done_cnt;

  int checkCount = 0;
  int passCount  = 0;

  // Behavioural model: per requester, whether a request is outstanding,
  // how many cycles it has waited, and whether it already timed out.
  bit mPending [N];
  bit mLate    [N];
  int mAge     [N];
  bit mTmo     [N];
  bit mProto   [N];
  int mDone    [N];
  int mMax     [N];

  bus_req_watchdog #(
    .NUM_CPUS      (N),
    .TIMEOUT_CYCLES(T),
    .CNT_W         (W)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .req         (req),
    .ack         (ack),
    .clear       (clear),
    .timeout_flag(timeout_flag),
    .proto_err   (proto_err),
    .timeout_any (timeout_any),
    .timeout_ch  (timeout_ch),
    .max_lat     (max_lat),
    .done_cnt    (done_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)",
               tag, observed, expected, $time);
    end
  endtask

  task automatic recordDone(input int ch, input int lat);
    if (mDone[ch] < CNT_SAT) mDone[ch]++;
    if (lat > mMax[ch]) mMax[ch] = lat;
  endtask

  task automatic updateModel(input logic r, input logic [N-1:0] rq,
                             input logic [N-1:0] ak, input logic [N-1:0] cl);
    for (int i = 0; i < N; i++) begin
      bit setT;
      bit setP;
      setT = 0;
      setP = 0;
      if (r) begin
        mPending[i] = 0; mLate[i] = 0; mAge[i] = 0;
        mTmo[i] = 0; mProto[i] = 0; mDone[i] = 0; mMax[i] = 0;
        continue;
      end
      if (mLate[i]) begin
        if (ak[i] || !rq[i]) mLate[i] = 0;
      end else if (!mPending[i]) begin
        if (rq[i] && ak[i]) begin
          recordDone(i, 0);
        end else if (rq[i]) begin
          mPending[i] = 1;
          mAge[i] = 1;
        end
      end else if (ak[i]) begin
        recordDone(i, mAge[i]);
        mPending[i] = 0;
      end else if (!rq[i]) begin
        setP = 1;
        mPending[i] = 0;
      end else begin
        mAge[i]++;
        if (mAge[i] == T) begin
          setT = 1;
          mPending[i] = 0;
          mLate[i] = 1;
        end
      end
      if (setT) mTmo[i] = 1; else if (cl[i]) mTmo[i] = 0;
      if (setP) mProto[i] = 1; else if (cl[i]) mProto[i] = 0;
    end
  endtask

  task automatic compareAll();
    logic [N-1:0]   expTmo;
    logic [N-1:0]   expProto;
    logic [N*W-1:0] expMax;
    logic [N*W-1:0] expDone;
    int             expCh;
    expCh = 0;
    for (int i = N - 1; i >= 0; i--) begin
      expTmo[i]   = mTmo[i];
      expProto[i] = mProto[i];
      if (mTmo[i]) expCh = i;
`ifdef WATCHDOG_STATS_EN
      expMax[i*W +: W]  = W'(mMax[i]);
      expDone[i*W +: W] = W'(mDone[i]);
`else
      expMax[i*W +: W]  = '0;
      expDone[i*W +: W] = '0;
`endif
    end
    checkOutput("timeout_flag", 64'(timeout_flag), 64'(expTmo));
    checkOutput("proto_err", 64'(proto_err), 64'(expProto));
    checkOutput("timeout_any", 64'(timeout_any), 64'(|expTmo));
    checkOutput("timeout_ch", 64'(timeout_ch), 64'(expCh));
    checkOutput("max_lat", 64'(max_lat), 64'(expMax));
    checkOutput("done_cnt", 64'(done_cnt), 64'(expDone));
  endtask

  task automatic applyStimulus(input logic r, input logic [N-1:0] rq,
                               input logic [N-1:0] ak, input logic [N-1:0] cl);
    RST   = r;
    req   = rq;
    ack   = ak;
    clear = cl;
    @(posedge CLK);
    updateModel(r, rq, ak, cl);
    #1;
    compareAll();
  endtask

  task automatic holdReq(input logic [N-1:0] rq, input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, rq, '0, '0);
  endtask

  initial begin
    logic [N-1:0] rndReq;
    logic [N-1:0] rndAck;
    logic [N-1:0] rndClr;
    logic         rndRst;

    $display("[TB] bus_req_watchdog bench start");
    RST = 1'b1; req = '0; ack = '0; clear = '0;
    applyStimulus(1'b1, '0, '0, '0);
    applyStimulus(1'b1, '0, '0, '0);
    checkOutput("reset_flags", 64'({timeout_flag, proto_err}), 64'd0);
    checkOutput("reset_stats", 64'(done_cnt), 64'd0);

    // Ch0 completes after a 5-cycle wait.
    holdReq(4'b0001, 5);
    applyStimulus(1'b0, 4'b0001, 4'b0001, '0);
    applyStimulus(1'b0, '0, '0, '0);
    checkOutput("ch0_noflag", 64'(timeout_flag[0]), 64'd0);
`ifdef WATCHDOG_STATS_EN
    checkOutput("ch0_done1", 64'(done_cnt[15:0]), 64'd1);
    checkOutput("ch0_max5", 64'(max_lat[15:0]), 64'd5);
`endif

    // Ch2 never acknowledged: flag rises exactly at cycle 20.
    holdReq(4'b0100, 19);
    checkOutput("ch2_noflag_c19", 64'(timeout_flag[2]), 64'd0);
    holdReq(4'b0100, 1);
    checkOutput("ch2_flag_c20", 64'(timeout_flag[2]), 64'd1);
    checkOutput("ch2_any", 64'(timeout_any), 64'd1);
    checkOutput("ch2_ch", 64'(timeout_ch), 64'd2);
    holdReq(4'b0100, 10);
    applyStimulus(1'b0, 4'b0100, 4'b0100, '0);
    applyStimulus(1'b0, '0, '0, '0);
    checkOutput("ch2_sticky", 64'(timeout_flag[2]), 64'd1);
    checkOutput("ch2_late_notdone", 64'(done_cnt[47:32]), 64'd0);
    applyStimulus(1'b0, '0, '0, 4'b0100);

    // Ch1 and ch3 time out together; clearing ch1 exposes ch3.
    holdReq(4'b1010, 20);
    checkOutput("dual_ch1", 64'(timeout_ch), 64'd1);
    applyStimulus(1'b0, 4'b1010, '0, 4'b0010);
    checkOutput("dual_ch3", 64'(timeout_ch), 64'd3);
    applyStimulus(1'b0, '0, '0, 4'b1111);

    // Ch3 drops its request; then a drop coinciding with clear.
    holdReq(4'b1000, 3);
    applyStimulus(1'b0, '0, '0, '0);
    checkOutput("ch3_proto", 64'(proto_err[3]), 64'd1);
    holdReq(4'b1000, 3);
    applyStimulus(1'b0, '0, '0, 4'b1000);
    checkOutput("ch3_set_beats_clr", 64'(proto_err[3]), 64'd1);
    applyStimulus(1'b0, '0, '0, 4'b1000);
    checkOutput("ch3_cleared", 64'(proto_err[3]), 64'd0);

    // Reset mid-wait on ch1, then a fresh 20-cycle timeout.
    holdReq(4'b0010, 10);
    applyStimulus(1'b1, 4'b0010, '0, '0);
    checkOutput("rst_all_flags", 64'({timeout_flag, proto_err, timeout_any, timeout_ch}), 64'd0);
    checkOutput("rst_stats", 64'(done_cnt | max_lat), 64'd0);
    holdReq(4'b0010, 19);
    checkOutput("rst_noflag_c19", 64'(timeout_flag[1]), 64'd0);
    holdReq(4'b0010, 1);
    checkOutput("rst_flag_c20", 64'(timeout_flag[1]), 64'd1);
    applyStimulus(1'b0, '0, '0, 4'b1111);

    // Ch0 zero-latency completions back to back.
    for (int k = 0; k < 3; k++) applyStimulus(1'b0, 4'b0001, 4'b0001, '0);
    applyStimulus(1'b0, '0, '0, '0);
`ifdef WATCHDOG_STATS_EN
    checkOutput("ch0_done3", 64'(done_cnt[15:0]), 64'd3);
    checkOutput("ch0_max0", 64'(max_lat[15:0]), 64'd0);
`endif

    // Random traffic: slowly changing requests, sparse acks/clears/resets.
    rndReq = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 15) == 0) rndReq[i] = ~rndReq[i];
        rndAck[i] = ($urandom_range(0, 9) == 0);
        rndClr[i] = ($urandom_range(0, 19) == 0);
      end
      rndRst = ($urandom_range(0, 299) == 0);
      applyStimulus(rndRst, rndReq, rndAck, rndClr);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
